qos_dest_demux: RTL and testbench
=================================

// Module: qos_dest_demux
// PURPOSE
//   Read-side consumer of the qos output queue: pops words whenever qos reports non-empty and
//   steers each word by its destination field into one of QUEUE_QUANTITY destination FIFOs.
//   Sits between qos and the downstream ports, and replaces the bench pop task in system builds.
//   Backpressure: a full destination stalls further pops from qos.
// PARAMETERS
//   QUEUE_QUANTITY  4  number of destination FIFOs (power of 2)
//   DATA_BITS       8  word width; destination = data[DATA_BITS-1 -: log2(QUEUE_QUANTITY)]
//   BUF_WIDTH       3  log2 depth of each destination FIFO (depth 8)
// PORTS
//   clk        in   1                          single clock, rising edge
//   reset      in   1                          asynchronous, active-high
//   in_empty   in   1                          qos output queue empty
//   in_data    in   DATA_BITS                  qos output word, valid the cycle after in_rd_en
//   in_rd_en   out  1                          pop request to qos
//   out_rd_en  in   QUEUE_QUANTITY             per-destination pop
//   out_data   out  QUEUE_QUANTITY*DATA_BITS   dest i at [i*DATA_BITS +: DATA_BITS], registered
//   out_empty  out  QUEUE_QUANTITY             per-destination empty
//   out_full   out  QUEUE_QUANTITY             per-destination full
//   drop_cnt   out  8                          dropped-word count (0 unless macro defined)
// BEHAVIOUR
//   Reset (async, active-high): state IDLE; all FIFOs empty; out_empty=all 1; out_full=0;
//     out_data=0; drop_cnt=0; in_rd_en forced 0. Reset mid-transfer discards the held/in-flight word.
//   FSM: IDLE / FETCH / HOLD.
//     IDLE : in_rd_en = !in_empty; if asserted -> FETCH.
//     FETCH: in_data valid; d = dest field. If !out_full[d], write it to FIFO d.
//            Same cycle, in_rd_en = !in_empty: if 1 stay FETCH (1 word/cycle); if 0 -> IDLE.
//            If out_full[d], latch word+d into hold reg, in_rd_en=0 -> HOLD.
//     HOLD : when !out_full[held d], write the held word; in_rd_en = !in_empty -> FETCH, else IDLE.
//            While full: in_rd_en=0 and stay in HOLD.
//   in_rd_en is combinational from state, FIFO full flags and in_empty; never high during reset.
//   Latency: in_data at cycle N+1 -> written edge N+1 -> out_empty falls after that edge.
//   Dest FIFO: wr/rd ptr BUF_WIDTH bits, wrap modulo depth; count BUF_WIDTH+1 bits.
//     full = count==2^BUF_WIDTH; empty = count==0.
//     out_rd_en on empty: ignored, out_data holds. Otherwise out_data gets the head word
//     after the edge (same read convention as qos).
//     Simultaneous push+pop: both execute, count unchanged; on empty, push wins, pop ignored.
//     No write ever occurs to a full FIFO.
//   Word ordering is preserved per destination.
// CONFIGURATION
//   QOS_DEMUX_DROP_EN defined:
//     FETCH to a full destination drops the word (no HOLD; HOLD unreachable).
//     drop_cnt increments and saturates at 255. in_rd_en continues at up to 1/cycle.
//   Not defined: stall/HOLD behaviour above; drop_cnt tied to 0.
// STRUCTURE
//   Shared include qos_defines.v: QUEUE_QUANTITY, DATA_BITS, BUF_WIDTH defaults, DEST_BITS,
//     FSM state encodings (IDLE=2'd0, FETCH=2'd1, HOLD=2'd2).
//   Sub-module qos_dest_fifo (one FIFO, instanced QUEUE_QUANTITY times via generate).
//   Top holds FSM, hold register, dest decode, drop counter.
// TESTING (bench drives in_empty/in_data as a qos model; compare against qosSynth-style synth copy)
//   1 reset mid-stream: reset while in HOLD -> next cycle in_rd_en=0, out_empty=4'b1111, drop_cnt=0.
//   2 routing: feed 8'h05, 8'h45, 8'h85, 8'hC5 back-to-back
//       -> in_rd_en high 4 consecutive cycles; each FIFO gets one word; out_empty=0 one cycle after each.
//   3 full/stall: fill dest 0 with 8 words 8'h00..8'h07 (no pops), then send 8'h08
//       -> out_full[0]=1, FSM HOLD, in_rd_en=0.
//       Pop one -> 8'h08 written the next cycle; order 00..08 preserved.
//   4 empty pop: out_rd_en[2]=1 on empty FIFO 2 -> out_data[2] unchanged, out_empty[2]=1.
//   5 simultaneous: FIFO 1 holds 3 words; push 8'h4A while popping
//       -> count stays 3, popped word = oldest.
//   6 QOS_DEMUX_DROP_EN: repeat scenario 3 -> 8'h08 discarded, drop_cnt=1, no stall.
//       300 extra drops -> drop_cnt=255.

Source files
------------

// File: rtl/qos_dest_demux_pkg.sv
// Shared sizing, FSM encoding and destination decode for the qos destination demux.
package qos_dest_demux_pkg;

  localparam int QUEUE_QUANTITY = 4;
  localparam int DATA_BITS      = 8;
  localparam int BUF_WIDTH      = 3;
  localparam int DEST_BITS      = $clog2(QUEUE_QUANTITY);
  localparam int FIFO_DEPTH     = 1 << BUF_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef logic [DATA_BITS-1:0] word_t;
  typedef logic [DEST_BITS-1:0] dest_t;

  function automatic dest_t dest_of(input word_t w);
    return w[DATA_BITS-1 -: DEST_BITS];
  endfunction

endpackage

// File: rtl/qos_dest_demux_if.sv
// Bus between the qos output queue, the demux and the downstream destination ports.
interface qos_dest_demux_if;
  import qos_dest_demux_pkg::*;

  // Pop handshake on both sides: a pop is taken at the rising edge where rd_en is high and
  // empty is low; the popped word appears on the data lines after that edge and holds until
  // the next accepted pop.
  logic                                in_empty;
  word_t                               in_data;
  logic                                in_rd_en;
  logic [QUEUE_QUANTITY-1:0]           out_rd_en;
  logic [QUEUE_QUANTITY*DATA_BITS-1:0] out_data;
  logic [QUEUE_QUANTITY-1:0]           out_empty;
  logic [QUEUE_QUANTITY-1:0]           out_full;

  modport master (
    input  in_empty, in_data, out_rd_en,
    output in_rd_en, out_data, out_empty, out_full
  );

  modport slave (
    output in_empty, in_data, out_rd_en,
    input  in_rd_en, out_data, out_empty, out_full
  );

endinterface

// File: rtl/qos_dest_demux_fifo.sv
// One destination FIFO: registered read data, pops on empty ignored, pushes on full ignored.
module qos_dest_demux_fifo
  import qos_dest_demux_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  wr_en,
  input  word_t wr_data,
  input  logic  rd_en,
  output word_t rd_data,
  output logic  empty,
  output logic  full
);

  logic [BUF_WIDTH-1:0] wr_ptr;
  logic [BUF_WIDTH-1:0] rd_ptr;
  logic [BUF_WIDTH:0]   count;
  word_t                mem [FIFO_DEPTH];
  logic                 do_wr;
  logic                 do_rd;

  assign empty = (count == '0);
  assign full  = (count == (BUF_WIDTH+1)'(FIFO_DEPTH));
  // On an empty FIFO a concurrent push wins and the pop is dropped.
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/qos_dest_demux.sv
// Pops the qos output queue and steers each word into a per-destination FIFO by its top bits.
// Build option QOS_DEMUX_DROP_EN: words for a full destination are dropped and counted instead of stalling.
module qos_dest_demux
  import qos_dest_demux_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  qos_dest_demux_if.master  bus,
  output logic [7:0]        drop_cnt,
  output state_t            state_dbg
);

  state_t                    state;
  state_t                    state_next;
  word_t                     hold_data;
  dest_t                     hold_dest;
  dest_t                     in_dest;
  logic                      hold_load;
  logic                      rd_req;
  logic [QUEUE_QUANTITY-1:0] wr_en;
  word_t                     wr_data;
  logic [QUEUE_QUANTITY-1:0] fifo_full;
  logic [QUEUE_QUANTITY-1:0] fifo_empty;
`ifdef QOS_DEMUX_DROP_EN
  logic                      drop_hit;
`endif

  assign in_dest   = dest_of(bus.in_data);
  assign state_dbg = state;
  assign bus.in_rd_en = rd_req && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    rd_req     = 1'b0;
    wr_en      = '0;
    wr_data    = bus.in_data;
    hold_load  = 1'b0;
`ifdef QOS_DEMUX_DROP_EN
    drop_hit   = 1'b0;
`endif
    case (state)
      IDLE: begin
        rd_req = !bus.in_empty;
        if (rd_req) state_next = FETCH;
      end
      FETCH: begin
        if (!fifo_full[in_dest]) begin
          wr_en[in_dest] = 1'b1;
          rd_req         = !bus.in_empty;
          state_next     = rd_req ? FETCH : IDLE;
        end else begin
`ifdef QOS_DEMUX_DROP_EN
          drop_hit   = 1'b1;
          rd_req     = !bus.in_empty;
          state_next = rd_req ? FETCH : IDLE;
`else
          hold_load  = 1'b1;
          state_next = HOLD;
`endif
        end
      end
      HOLD: begin
        wr_data = hold_data;
        if (!fifo_full[hold_dest]) begin
          wr_en[hold_dest] = 1'b1;
          rd_req           = !bus.in_empty;
          state_next       = rd_req ? FETCH : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_data <= '0;
      hold_dest <= '0;
    end else if (hold_load) begin
      hold_data <= bus.in_data;
      hold_dest <= in_dest;
    end
  end

`ifdef QOS_DEMUX_DROP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             drop_cnt <= '0;
    else if (drop_hit && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
  end
`else
  assign drop_cnt = '0;
`endif

  for (genvar i = 0; i < QUEUE_QUANTITY; i++) begin : g_fifo
    qos_dest_demux_fifo u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en[i]),
      .wr_data (wr_data),
      .rd_en   (bus.out_rd_en[i]),
      .rd_data (bus.out_data[i*DATA_BITS +: DATA_BITS]),
      .empty   (fifo_empty[i]),
      .full    (fifo_full[i])
    );
  end

  assign bus.out_empty = fifo_empty;
  assign bus.out_full  = fifo_full;

endmodule

// File: tb/tb_qos_dest_demux.sv
// Bench for qos_dest_demux: a qos queue model feeds words, per-destination expected queues check output order.
module tb_qos_dest_demux;
  import qos_dest_demux_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] drop_cnt;
  state_t     state_dbg;

  qos_dest_demux_if bus ();

  qos_dest_demux dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .drop_cnt  (drop_cnt),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  word_t                 src_q[$];
  logic [DATA_BITS-1:0]  exp_q[QUEUE_QUANTITY][$];
  word_t                 last_out[QUEUE_QUANTITY];
  int                    tests_run = 0;
  int                    tests_failed = 0;

  // qos output queue model: pop seen before the edge, word presented 1 ns after it.
  initial begin
    logic rd;
    bus.in_empty = 1'b1;
    bus.in_data  = '0;
    forever begin
      @(negedge clk);
      rd = bus.in_rd_en;
      @(posedge clk);
      #1;
      if (rd && src_q.size() > 0) bus.in_data = src_q.pop_front();
      bus.in_empty = (src_q.size() == 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_word(input word_t w, input bit keep);
    src_q.push_back(w);
    if (keep) exp_q[dest_of(w)].push_back(w);
  endtask

  task automatic clear_model();
    src_q.delete();
    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      exp_q[i].delete();
      last_out[i] = '0;
    end
  endtask

  task automatic pop_check(input int d, input string name);
    word_t got, exp;
    bus.out_rd_en[d] = 1'b1;
    tick();
    bus.out_rd_en = '0;
    got = bus.out_data[d*DATA_BITS +: DATA_BITS];
    tests_run++;
    if (exp_q[d].size() == 0) begin
      tests_failed++;
      $display("FAIL %s: popped dest %0d got %h but no word expected", name, d, got);
    end else begin
      exp = exp_q[d].pop_front();
      last_out[d] = exp;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL %s: dest %0d out_data got %h expected %h", name, d, got, exp);
      end
    end
  endtask

  task automatic wait_idle(input int max_cycles, input string name);
    int n = 0;
    tick();
    while (!(bus.in_empty && state_dbg == IDLE) && n < max_cycles) begin
      tick();
      n++;
    end
    tests_run++;
    if (n >= max_cycles) begin
      tests_failed++;
      $display("FAIL %s: no return to IDLE within %0d cycles, state %0d", name, max_cycles, state_dbg);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.out_rd_en = '0;
    clear_model();
    src_q.push_back(8'h11);
    tick();
    tick();
    tests_run++;
    if (bus.in_rd_en !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_en: got %b expected 0", bus.in_rd_en); end
    tests_run++;
    if (bus.out_empty !== 4'b1111) begin tests_failed++; $display("FAIL reset_empty: got %b expected 1111", bus.out_empty); end
    tests_run++;
    if (bus.out_full !== 4'b0000) begin tests_failed++; $display("FAIL reset_full: got %b expected 0000", bus.out_full); end
    tests_run++;
    if (bus.out_data !== 32'h0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0", bus.out_data); end
    tests_run++;
    if (drop_cnt !== 8'h00) begin tests_failed++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
    tests_run++;
    if (state_dbg !== IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d expected IDLE", state_dbg); end
    src_q.delete();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_routing();
    logic [3:0] exp_empty;
    push_word(8'h05, 1'b1);
    push_word(8'h45, 1'b1);
    push_word(8'h85, 1'b1);
    push_word(8'hC5, 1'b1);
    tick();
    for (int k = 0; k < 6; k++) begin
      exp_empty = 4'b1111;
      for (int j = 0; j < 4; j++) if (j <= k - 2) exp_empty[j] = 1'b0;
      tests_run++;
      if (bus.in_rd_en !== (k < 4)) begin
        tests_failed++;
        $display("FAIL routing_rd_en: cycle %0d got %b expected %b", k, bus.in_rd_en, (k < 4));
      end
      tests_run++;
      if (bus.out_empty !== exp_empty) begin
        tests_failed++;
        $display("FAIL routing_empty: cycle %0d got %b expected %b", k, bus.out_empty, exp_empty);
      end
      tick();
    end
    for (int d = 0; d < 4; d++) pop_check(d, "routing_data");
  endtask

  task automatic test_empty_pop();
    bus.out_rd_en[2] = 1'b1;
    tick();
    bus.out_rd_en = '0;
    tests_run++;
    if (bus.out_data[2*DATA_BITS +: DATA_BITS] !== last_out[2]) begin
      tests_failed++;
      $display("FAIL empty_pop_data: got %h expected %h", bus.out_data[2*DATA_BITS +: DATA_BITS], last_out[2]);
    end
    tests_run++;
    if (bus.out_empty[2] !== 1'b1) begin tests_failed++; $display("FAIL empty_pop_flag: got %b expected 1", bus.out_empty[2]); end
  endtask

  task automatic test_simultaneous();
    push_word(8'h41, 1'b1);
    push_word(8'h42, 1'b1);
    push_word(8'h43, 1'b1);
    wait_idle(20, "simul_fill");
    push_word(8'h4A, 1'b1);
    tick();
    tick();
    // FETCH of 8'h4A: its write lands on the same edge as this pop
    pop_check(1, "simul_oldest");
    tests_run++;
    if (bus.out_empty[1] !== 1'b0) begin tests_failed++; $display("FAIL simul_empty: got %b expected 0", bus.out_empty[1]); end
    for (int i = 0; i < 3; i++) pop_check(1, "simul_rest");
    tests_run++;
    if (bus.out_empty[1] !== 1'b1) begin tests_failed++; $display("FAIL simul_count: out_empty got %b expected 1 after 3 pops", bus.out_empty[1]); end
  endtask

  task automatic test_full_stall();
    for (int w = 0; w < 8; w++) push_word(word_t'(w), 1'b1);
    wait_idle(40, "stall_fill");
    tests_run++;
    if (bus.out_full[0] !== 1'b1) begin tests_failed++; $display("FAIL stall_full: got %b expected 1", bus.out_full[0]); end
`ifdef QOS_DEMUX_DROP_EN
    push_word(8'h08, 1'b0);
    tick();
    tick();
    tick();
    tests_run++;
    if (state_dbg !== IDLE) begin tests_failed++; $display("FAIL drop_state: got %0d expected IDLE", state_dbg); end
    tests_run++;
    if (drop_cnt !== 8'd1) begin tests_failed++; $display("FAIL drop_cnt1: got %0d expected 1", drop_cnt); end
    for (int i = 0; i < 300; i++) push_word(word_t'(i % 64), 1'b0);
    wait_idle(400, "drop_stream");
    tests_run++;
    if (drop_cnt !== 8'd255) begin tests_failed++; $display("FAIL drop_sat: got %0d expected 255", drop_cnt); end
    for (int i = 0; i < 8; i++) pop_check(0, "drop_order");
`else
    push_word(8'h08, 1'b1);
    tick();
    tick();
    tick();
    tests_run++;
    if (state_dbg !== HOLD) begin tests_failed++; $display("FAIL stall_state: got %0d expected HOLD", state_dbg); end
    tests_run++;
    if (bus.in_rd_en !== 1'b0) begin tests_failed++; $display("FAIL stall_rd_en: got %b expected 0", bus.in_rd_en); end
    tick();
    tick();
    tests_run++;
    if (state_dbg !== HOLD) begin tests_failed++; $display("FAIL stall_stays: got %0d expected HOLD", state_dbg); end
    pop_check(0, "stall_first");
    tick();
    tests_run++;
    if (state_dbg !== IDLE) begin tests_failed++; $display("FAIL stall_release: got %0d expected IDLE", state_dbg); end
    tests_run++;
    if (bus.out_full[0] !== 1'b1) begin tests_failed++; $display("FAIL stall_refill: got %b expected 1", bus.out_full[0]); end
    for (int i = 0; i < 8; i++) pop_check(0, "stall_order");
`endif
    tests_run++;
    if (bus.out_empty[0] !== 1'b1) begin tests_failed++; $display("FAIL stall_drain: got %b expected 1", bus.out_empty[0]); end
  endtask

  task automatic test_random();
    logic [3:0] mask;
    word_t      got, exp;
    int         n = 0;
    bit         busy;
    for (int i = 0; i < 16; i++) push_word({2'(i % 4), 6'($urandom_range(0, 63))}, 1'b1);
    tick();
    busy = 1'b1;
    while (busy && n < 300) begin
      mask = 4'($urandom_range(0, 15)) & ~bus.out_empty;
      bus.out_rd_en = mask;
      tick();
      bus.out_rd_en = '0;
      for (int d = 0; d < 4; d++) begin
        if (mask[d]) begin
          got = bus.out_data[d*DATA_BITS +: DATA_BITS];
          exp = exp_q[d].pop_front();
          last_out[d] = exp;
          tests_run++;
          if (got !== exp) begin
            tests_failed++;
            $display("FAIL random_data: dest %0d got %h expected %h", d, got, exp);
          end
        end
      end
      busy = (src_q.size() != 0) || !bus.in_empty || (state_dbg != IDLE);
      for (int d = 0; d < 4; d++) if (exp_q[d].size() != 0) busy = 1'b1;
      n++;
    end
    tests_run++;
    if (busy) begin tests_failed++; $display("FAIL random_timeout: words still pending after %0d cycles", n); end
  endtask

  task automatic test_reset_mid();
    for (int w = 0; w < 8; w++) push_word(word_t'(w), 1'b1);
    wait_idle(40, "mid_fill");
    push_word(8'h08, 1'b0);
    push_word(8'h49, 1'b0);
    push_word(8'h4B, 1'b0);
    tick();
    tick();
    tick();
`ifdef QOS_DEMUX_DROP_EN
    tests_run++;
    if (drop_cnt !== 8'd255) begin tests_failed++; $display("FAIL mid_drop_pre: got %0d expected 255", drop_cnt); end
`else
    tests_run++;
    if (state_dbg !== HOLD) begin tests_failed++; $display("FAIL mid_hold: got %0d expected HOLD", state_dbg); end
`endif
    reset = 1'b1;
    tick();
    tests_run++;
    if (bus.in_rd_en !== 1'b0) begin tests_failed++; $display("FAIL mid_rd_en: got %b expected 0", bus.in_rd_en); end
    tests_run++;
    if (bus.out_empty !== 4'b1111) begin tests_failed++; $display("FAIL mid_empty: got %b expected 1111", bus.out_empty); end
    tests_run++;
    if (drop_cnt !== 8'd0) begin tests_failed++; $display("FAIL mid_drop: got %0d expected 0", drop_cnt); end
    clear_model();
    tick();
    reset = 1'b0;
    tick();
    tick();
    tests_run++;
    if (state_dbg !== IDLE || bus.out_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL mid_after: state %0d data %h expected IDLE and 0", state_dbg, bus.out_data);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.out_rd_en = '0;
    for (int i = 0; i < QUEUE_QUANTITY; i++) last_out[i] = '0;
    test_reset();
    test_routing();
    test_empty_pop();
    test_simultaneous();
    test_full_stall();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
